// File: rtl/ser_pkg.sv
// Shared definitions for the word serializer: state encoding, shift order
// constants and the counter-width helper.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam bit LSB_FIRST       = 1'b0;
  localparam bit MSB_FIRST_ORDER = 1'b1;

  // Smallest r with 2**r >= value; constant-foldable for parameter use.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, zero-fill shift register; bit_o is the end that leaves first.
module piso_shift_reg
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = LSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             bit_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      if (MSB_FIRST == MSB_FIRST_ORDER) shreg_d = shreg_q << 1;
      else                              shreg_d = shreg_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) shreg_q <= '0;
    else     shreg_q <= shreg_d;
  end

  assign data_o = shreg_q;
  assign bit_o  = (MSB_FIRST == MSB_FIRST_ORDER) ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/word_serializer.sv
// Word-to-bitstream unloader: load/ready word handshake in, valid/ready
// serial stream out, with ser_last flagging the final bit of each word.
//
// state | meaning
// IDLE  | ready for a word, no serial output
// SHIFT | presenting one bit per beat until the last bit is accepted
module word_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             load_i,
  output logic             ready_o,
  output logic             ser_out_o,
  output logic             ser_valid_o,
  input  logic             ser_ready_i,
  output logic             ser_last_o
);

  localparam int            CW       = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          ready_q;
  logic          valid_q;
  logic          last_q;
  logic          accept;
  logic          beat;
  logic [WIDTH-1:0] unused_shreg;

  assign accept = ready_q & load_i;
  assign beat   = valid_q & ser_ready_i;
  assign cnt_d  = cnt_q + CW'(1);

  // Handshake flags are registered alongside the state so no output sees
  // load_i or ser_ready_i combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (beat) begin
            if (last_q) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              ready_q <= 1'b1;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              cnt_q  <= cnt_d;
              last_q <= (cnt_d == LAST_CNT);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .shift_i (beat),
    .data_i  (data_in_i),
    .data_o  (unused_shreg),
    .bit_o   (ser_out_o)
  );

  assign ready_o     = ready_q;
  assign ser_valid_o = valid_q;
  assign ser_last_o  = last_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed plus randomized bench for word_serializer: an LSB-first and an
// MSB-first instance checked against a bit-queue reference model.
module tb_word_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [2];
  logic [1:0] load;
  logic [1:0] sready;
  logic [1:0] rdy;
  logic [1:0] sout;
  logic [1:0] svld;
  logic [1:0] slast;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk         (clk),
    .rst         (rst),
    .data_in_i   (din[0]),
    .load_i      (load[0]),
    .ready_o     (rdy[0]),
    .ser_out_o   (sout[0]),
    .ser_valid_o (svld[0]),
    .ser_ready_i (sready[0]),
    .ser_last_o  (slast[0])
  );

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk         (clk),
    .rst         (rst),
    .data_in_i   (din[1]),
    .load_i      (load[1]),
    .ready_o     (rdy[1]),
    .ser_out_o   (sout[1]),
    .ser_valid_o (svld[1]),
    .ser_ready_i (sready[1]),
    .ser_last_o  (slast[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int s, input string tag);
    check({tag, "_ready"}, rdy[s], 1'b1);
    check({tag, "_valid"}, svld[s], 1'b0);
    check({tag, "_last"}, slast[s], 1'b0);
    check({tag, "_out"}, sout[s], 1'b0);
  endtask

  // mode 0: ser_ready held high; 1: random ser_ready and random stray loads;
  // 2: 3-cycle stall once bits 0..2 are accepted; 3: load=1 with 8'hFF throughout.
  // abort_at >= 0 pulses rst while bit abort_at is on the line.
  task automatic run_word(input int s, input logic [7:0] w, input int mode, input int abort_at);
    bit bits[$];
    int idx;
    int stall;
    int guard;
    bit r;
    for (int i = 0; i < 8; i++) bits.push_back((s == 1) ? w[7-i] : w[i]);

    check_idle(s, "pre_load");
    din[s]    = w;
    load[s]   = 1'b1;
    sready[s] = 1'($urandom_range(0, 1));
    tick();
    load[s] = 1'b0;
    din[s]  = 8'($urandom);

    idx = 0; stall = 0; guard = 0;
    while (idx < 8 && guard < 200) begin
      guard++;
      check("bit_valid", svld[s], 1'b1);
      check("bit_ready", rdy[s], 1'b0);
      check("bit_out", sout[s], bits[idx]);
      check("bit_last", slast[s], (idx == 7));
      if (idx == abort_at) begin
        load[s] = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        check_idle(s, "abort");
        return;
      end
      case (mode)
        1:       r = 1'($urandom_range(0, 1));
        2: begin
          r = !(idx == 3 && stall < 3);
          if (!r) stall++;
        end
        default: r = 1'b1;
      endcase
      sready[s] = r;
      load[s]   = (mode == 3) || (mode == 1 && $urandom_range(0, 1) == 1);
      din[s]    = (mode == 3) ? 8'hFF : 8'($urandom);
      tick();
      if (r) idx++;
    end
    check("word_complete", idx, 8);
    if (mode == 2) check("stall_cycles", stall, 3);

    load[s]   = 1'b0;
    sready[s] = 1'($urandom_range(0, 1));
    check_idle(s, "post_word");
    tick();
    check_idle(s, "idle_hold");
  endtask

  initial begin
    load   = '0;
    sready = '0;
    din[0] = 8'h00;
    din[1] = 8'h00;

    rst = 1'b1;
    tick();
    tick();
    check_idle(0, "reset_lsb");
    check_idle(1, "reset_msb");
    rst = 1'b0;
    tick();
    check_idle(0, "released_lsb");

    run_word(0, 8'hA5, 0, -1);
    run_word(0, 8'h3C, 2, -1);
    run_word(0, 8'h00, 3, -1);
    run_word(1, 8'hC1, 0, -1);
    run_word(0, 8'hF0, 0, 4);
    run_word(0, 8'h81, 0, -1);
    run_word(1, 8'hF0, 1, 2);
    run_word(1, 8'h81, 2, -1);

    for (int n = 0; n < 30; n++) begin
      run_word(int'($urandom_range(0, 1)), 8'($urandom), 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
